// File: rtl/reg_pipeline_if.sv
// Valid/ready/data handshake bundle used on both ends of reg_pipeline.
interface reg_pipeline_if #(
  parameter int WIDTH = 7
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/reg_pipeline.sv
// Elastic DEPTH-stage register pipeline with valid/ready on both ends and bubble collapsing.
// Optional synchronous flush port is enabled by defining REG_PIPE_FLUSH_EN.
module reg_pipeline_stage #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_i,
  input  logic             clr_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i)     valid_d = 1'b0;
    else if (ld_i) valid_d = up_valid_i;
    // data only moves with a real word; bubbles leave stale data behind
    if (ld_i && up_valid_i && !clr_i) data_d = up_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

module reg_pipeline #(
  parameter  int WIDTH = 7,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef REG_PIPE_FLUSH_EN
  input  logic          flush_i,
`endif
  input  logic          en_i,
  reg_pipeline_if.slave  in_if,
  reg_pipeline_if.master out_if,
  output logic [CW-1:0] occupancy_o
);
  logic                        flush_w;
  logic [DEPTH-1:0]            vld, rdy, up_vld;
  logic [DEPTH-1:0][WIDTH-1:0] dat, up_dat;
  logic                        in_ready, out_valid, in_xfer, out_xfer;
  logic [CW-1:0]               occ_q, occ_d;

`ifdef REG_PIPE_FLUSH_EN
  assign flush_w = flush_i;
`else
  assign flush_w = 1'b0;
`endif

  // readiness ripples from the output back so a stalled tail still lets bubbles fill
  always_comb begin
    rdy            = '0;
    rdy[DEPTH-1]   = !vld[DEPTH-1] || out_if.ready;
    for (int i = DEPTH-2; i >= 0; i--) rdy[i] = !vld[i] || rdy[i+1];
  end

  assign in_ready     = en_i && rdy[0] && !flush_w;
  assign out_valid    = en_i && vld[DEPTH-1] && !flush_w;
  assign in_xfer      = in_if.valid && in_ready;
  assign out_xfer     = out_valid && out_if.ready;
  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = dat[DEPTH-1];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign up_vld[g] = in_xfer;
      assign up_dat[g] = in_if.data;
    end else begin : g_body
      assign up_vld[g] = vld[g-1];
      assign up_dat[g] = dat[g-1];
    end
    reg_pipeline_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .ld_i       (en_i && rdy[g]),
      .clr_i      (flush_w),
      .up_valid_i (up_vld[g]),
      .up_data_i  (up_dat[g]),
      .valid_o    (vld[g]),
      .data_o     (dat[g])
    );
  end

  always_comb begin
    occ_d = occ_q;
    if (flush_w) occ_d = '0;
    else begin
      case ({in_xfer, out_xfer})
        2'b10:   occ_d = occ_q + CW'(1);
        2'b01:   occ_d = occ_q - CW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occupancy_o = occ_q;
endmodule
